// File: rtl/arith_float_pkg.sv
// Shared float-format helpers for the arith library: field widths, the
// canonical quiet NaN pattern and the min/max operation encoding.
package arith_float_pkg;

  localparam logic OP_MIN = 1'b0;
  localparam logic OP_MAX = 1'b1;

  function automatic int exp_width(input int dw);
    case (dw)
      32'd16:  return 32'd5;
      32'd32:  return 32'd8;
      32'd64:  return 32'd11;
      default: return 32'd8;
    endcase
  endfunction

  function automatic int man_width(input int dw);
    return dw - 32'd1 - exp_width(dw);
  endfunction

  // Sign 0, exponent all ones, mantissa MSB set, remaining mantissa bits 0.
  function automatic logic [63:0] canonical_qnan(input int dw);
    logic [63:0] q;
    int          e;
    int          m;
    e = exp_width(dw);
    m = man_width(dw);
    q = ((64'd1 << e) - 64'd1) << m;
    q = q | (64'd1 << (m - 32'd1));
    return q;
  endfunction

endpackage

// File: rtl/fp_minmax_core.sv
// Combinational IEEE-754 min/max selector with defined NaN and signed-zero
// ordering; shared with future clamp-style operators.
module fp_minmax_core
  import arith_float_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CANONICAL_NAN = 1
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  op_max,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  is_nan
);

  localparam int EW = exp_width(DATA_WIDTH);
  localparam int MW = man_width(DATA_WIDTH);
  localparam logic [63:0] QNAN_FULL = canonical_qnan(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] QNAN = QNAN_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] QUIET_BIT = {{(EW + 1){1'b0}}, 1'b1, {(MW - 1){1'b0}}};

  logic a_nan_s;
  logic b_nan_s;
  logic a_lt_b_s;
  logic sel_a_s;

  assign a_nan_s = (&a[DATA_WIDTH-2 -: EW]) && (|a[MW-1:0]);
  assign b_nan_s = (&b[DATA_WIDTH-2 -: EW]) && (|b[MW-1:0]);

  // Total order on non-NaN operands: sign first, then magnitude (reversed when negative).
  always_comb begin
    a_lt_b_s = 1'b0;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
      a_lt_b_s = a[DATA_WIDTH-1];
    end else if (!a[DATA_WIDTH-1]) begin
      a_lt_b_s = (a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0]);
    end else begin
      a_lt_b_s = (a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0]);
    end
  end

  assign sel_a_s = (a == b) || ((op_max == OP_MAX) ? !a_lt_b_s : a_lt_b_s);

  // Result select: NaN propagation overrides the ordered pick.
  always_comb begin
    is_nan = a_nan_s || b_nan_s;
    y      = sel_a_s ? a : b;
    if (is_nan) begin
      if (CANONICAL_NAN != 0) begin
        y = QNAN;
      end else if (a_nan_s) begin
        y = a | QUIET_BIT;
      end else begin
        y = b | QUIET_BIT;
      end
    end else begin
      y = sel_a_s ? a : b;
    end
  end

endmodule

// File: rtl/minmaxf_pipe.sv
// Elastic float min/max operator: joins lhs/rhs, computes the selection and
// carries it through LATENCY stallable stages whose bubbles collapse.
module minmaxf_pipe
  import arith_float_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2,
  parameter int CANONICAL_NAN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic                  lhs_op_max,
  input  logic                  lhs_valid,
  output logic                  lhs_ready,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  rhs_valid,
  output logic                  rhs_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("minmaxf_pipe: DATA_WIDTH must be 16, 32 or 64");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("minmaxf_pipe: LATENCY must be in 1..8");
  end

  logic [LATENCY-1:0]    v_r;
  logic [DATA_WIDTH-1:0] d_r [LATENCY];
  logic [LATENCY-1:0]    adv_s;
  logic                  fire_s;
  logic [DATA_WIDTH-1:0] y_s;
  logic                  nan_unused_s;

  fp_minmax_core #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CANONICAL_NAN (CANONICAL_NAN)
  ) u_core (
    .a      (lhs),
    .b      (rhs),
    .op_max (lhs_op_max),
    .y      (y_s),
    .is_nan (nan_unused_s)
  );

  // Ready chain: a stage may load when it is empty or the stage ahead moves.
  always_comb begin
    adv_s = '0;
    adv_s[LATENCY-1] = !v_r[LATENCY-1] || result_ready;
    for (int i = LATENCY - 2; i >= 0; i--) begin
      adv_s[i] = !v_r[i] || adv_s[i+1];
    end
  end

  assign fire_s    = lhs_valid && rhs_valid && adv_s[0];
  assign lhs_ready = adv_s[0] && rhs_valid;
  assign rhs_ready = adv_s[0] && lhs_valid;

  // Stage registers; data only moves with a valid token to limit toggling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        d_r[i] <= '0;
      end
    end else begin
      if (adv_s[0]) begin
        v_r[0] <= fire_s;
        if (fire_s) begin
          d_r[0] <= y_s;
        end
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (adv_s[i]) begin
          v_r[i] <= v_r[i-1];
          if (v_r[i-1]) begin
            d_r[i] <= d_r[i-1];
          end
        end
      end
    end
  end

  assign result       = d_r[LATENCY-1];
  assign result_valid = v_r[LATENCY-1];

endmodule

// File: tb/tb_minmaxf_pipe.sv
// Randomised and directed bench for minmaxf_pipe; two instances (canonical
// and payload NaN modes) share stimulus and are checked against a queue model.
module tb_minmaxf_pipe;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lhs;
  logic        lhs_op_max;
  logic        lhs_valid;
  logic [31:0] rhs;
  logic        rhs_valid;
  logic        result_ready;
  logic        lhs_ready1, rhs_ready1, result_valid1;
  logic        lhs_ready0, rhs_ready0, result_valid0;
  logic [31:0] result1, result0;

  always #5 clk = ~clk;

  minmaxf_pipe #(.DATA_WIDTH(32), .LATENCY(LAT), .CANONICAL_NAN(1)) dut1 (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_op_max(lhs_op_max), .lhs_valid(lhs_valid),
    .lhs_ready(lhs_ready1), .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready1),
    .result(result1), .result_valid(result_valid1), .result_ready(result_ready));

  minmaxf_pipe #(.DATA_WIDTH(32), .LATENCY(LAT), .CANONICAL_NAN(0)) dut0 (
    .clk(clk), .rst(rst), .lhs(lhs), .lhs_op_max(lhs_op_max), .lhs_valid(lhs_valid),
    .lhs_ready(lhs_ready0), .rhs(rhs), .rhs_valid(rhs_valid), .rhs_ready(rhs_ready0),
    .result(result0), .result_valid(result_valid0), .result_ready(result_ready));

  typedef struct {
    logic [31:0] v1;
    logic [31:0] v0;
    int          fc;
  } tok_t;

  tok_t        q[$];
  logic [31:0] out1_q[$];
  logic [31:0] out0_q[$];
  int          cyc;
  int          last_cons;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] x);
    int  e;
    real m;
    real r;
    e = int'(x[30:23]);
    m = $itor({9'd0, x[22:0]});
    if (e == 255)    r = 1.0e300;
    else if (e == 0) r = m * (2.0 ** (-149));
    else             r = (m + 8388608.0) * (2.0 ** (e - 150));
    return x[31] ? -r : r;
  endfunction

  function automatic logic [31:0] ref_minmax(input logic [31:0] a, input logic [31:0] b,
                                             input logic op_max, input logic canon);
    logic lt;
    real  va, vb;
    if (is_nan(a) || is_nan(b)) begin
      if (canon) return 32'h7FC00000;
      return is_nan(a) ? (a | 32'h00400000) : (b | 32'h00400000);
    end
    if (a == b) return a;
    va = to_real(a);
    vb = to_real(b);
    if (va == vb) lt = a[31];  // only +0 / -0 reach here
    else          lt = (va < vb);
    if (op_max) return lt ? b : a;
    return lt ? a : b;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r = {r[31], 31'd0};
      1: r = {r[31], 8'hFF, 23'd0};
      2: r = {r[31], 8'hFF, r[22:1], 1'b1};
      3: r = {r[31], 8'h00, r[22:0]};
      4: r = {r[31], 8'h7F, r[22:21], 21'd0};
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // One clock: drive at negedge, check outputs/readies against the model, update at posedge.
  task automatic step(input logic lv, input logic [31:0] la, input logic op,
                      input logic rv, input logic [31:0] rb, input logic rr, output logic hs);
    logic exp_v;
    logic adv0;
    logic fire;
    @(negedge clk);
    lhs_valid = lv; lhs = la; lhs_op_max = op;
    rhs_valid = rv; rhs = rb; result_ready = rr;
    #1;
    exp_v = 1'b0;
    if (q.size() > 0) exp_v = (cyc >= q[0].fc + LAT) && (cyc >= last_cons + 1);
    check_eq("result_valid", {62'd0, result_valid1, result_valid0}, {62'd0, exp_v, exp_v});
    if (exp_v) begin
      check_eq("result_canon", {32'd0, result1}, {32'd0, q[0].v1});
      check_eq("result_payload", {32'd0, result0}, {32'd0, q[0].v0});
    end
    adv0 = (q.size() < LAT) || (exp_v && rr);
    check_eq("ready", {60'd0, lhs_ready1, rhs_ready1, lhs_ready0, rhs_ready0},
             {60'd0, adv0 && rv, adv0 && lv, adv0 && rv, adv0 && lv});
    hs = lv && lhs_ready1;
    if (result_valid1 && rr) begin
      out1_q.push_back(result1);
      out0_q.push_back(result0);
    end
    fire = lv && rv && adv0;
    @(posedge clk);
    if (exp_v && rr) begin
      void'(q.pop_front());
      last_cons = cyc;
    end
    if (fire) q.push_back('{ref_minmax(la, rb, op, 1'b1), ref_minmax(la, rb, op, 1'b0), cyc});
    cyc++;
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, hs);
  endtask

  logic [31:0] bp_tok [4];
  logic        hs;
  int          hs_cnt;
  int          tok_idx;

  initial begin
    bp_tok = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    rst = 1'b0; lhs = 32'd0; rhs = 32'd0; lhs_op_max = 1'b0;
    lhs_valid = 1'b0; rhs_valid = 1'b0; result_ready = 1'b1;
    cyc = 0; last_cons = -100;
    #12;
    check_eq("reset_valid", {62'd0, result_valid1, result_valid0}, 64'd0);
    check_eq("reset_result", {result1, result0}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Ordered min then max, back to back.
    out1_q.delete(); out0_q.delete();
    step(1'b1, 32'h3F800000, 1'b0, 1'b1, 32'h40000000, 1'b1, hs);
    step(1'b1, 32'h3F800000, 1'b1, 1'b1, 32'h40000000, 1'b1, hs);
    idle(3);
    check_eq("basic_count", out1_q.size(), 64'd2);
    if (out1_q.size() == 2) begin
      check_eq("basic_min", {32'd0, out1_q[0]}, 64'h3F800000);
      check_eq("basic_max", {32'd0, out1_q[1]}, 64'h40000000);
    end

    // Signed zero.
    out1_q.delete(); out0_q.delete();
    step(1'b1, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 1'b1, hs);
    step(1'b1, 32'h80000000, 1'b1, 1'b1, 32'h00000000, 1'b1, hs);
    idle(3);
    check_eq("zero_count", out1_q.size(), 64'd2);
    if (out1_q.size() == 2) begin
      check_eq("zero_min", {32'd0, out1_q[0]}, 64'h80000000);
      check_eq("zero_max", {32'd0, out1_q[1]}, 64'h00000000);
    end

    // NaN handling in both modes.
    out1_q.delete(); out0_q.delete();
    step(1'b1, 32'h7F800001, 1'b0, 1'b1, 32'h3F800000, 1'b1, hs);
    step(1'b1, 32'hFF800000, 1'b1, 1'b1, 32'hFF900000, 1'b1, hs);
    idle(3);
    check_eq("nan_count", out0_q.size(), 64'd2);
    if (out0_q.size() == 2) begin
      check_eq("nan_canon", {32'd0, out1_q[0]}, 64'h7FC00000);
      check_eq("nan_payload_lhs", {32'd0, out0_q[0]}, 64'h7FC00001);
      check_eq("nan_payload_rhs", {32'd0, out0_q[1]}, 64'hFFD00000);
    end

    // Backpressure: only LATENCY tokens fit while the sink stalls.
    out1_q.delete(); out0_q.delete();
    hs_cnt = 0; tok_idx = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, bp_tok[tok_idx], 1'b1, 1'b1, 32'hFF800000, 1'b0, hs);
      if (hs && tok_idx < 3) tok_idx++;
      if (hs) hs_cnt++;
    end
    check_eq("bp_accepted", hs_cnt, 64'd2);
    for (int c = 0; c < 20 && hs_cnt < 4; c++) begin
      step(1'b1, bp_tok[hs_cnt], 1'b1, 1'b1, 32'hFF800000, 1'b1, hs);
      if (hs) hs_cnt++;
    end
    idle(4);
    check_eq("bp_count", out1_q.size(), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < out1_q.size()) check_eq("bp_order", {32'd0, out1_q[k]}, {32'd0, bp_tok[k]});
    end

    // Join skew: lone lhs must not be consumed.
    hs_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 32'h40A00000, 1'b0, 1'b0, 32'd0, 1'b1, hs);
      if (hs) hs_cnt++;
    end
    step(1'b1, 32'h40A00000, 1'b0, 1'b1, 32'hC0A00000, 1'b1, hs);
    if (hs) hs_cnt++;
    idle(3);
    check_eq("skew_fires", hs_cnt, 64'd1);

    // Reset with two tokens in flight.
    step(1'b1, 32'h41000000, 1'b0, 1'b1, 32'h41100000, 1'b1, hs);
    step(1'b1, 32'h41200000, 1'b1, 1'b1, 32'h41300000, 1'b1, hs);
    @(negedge clk);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("midreset_valid", {62'd0, result_valid1, result_valid0}, 64'd0);
    check_eq("midreset_result", {result1, result0}, 64'd0);
    q.delete();
    last_cons = -100;
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] a, b;
      a = rand_fp();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h00000001;
        default: b = rand_fp();
      endcase
      step($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, b, $urandom_range(0, 3) != 0, hs);
    end
    idle(10);
    check_eq("drained", q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/minmaxf_pipe.md
Name: minmaxf_pipe

Overview:
- Elastic, parametrised IEEE-754 floating-point minimum/maximum unit with a native comparator; it uses no vendor IP.
- Joins the lhs and rhs channels, selects min or max per token, and carries the result through LATENCY stallable pipeline registers.
- Next generation of the float min dataflow unit: configurable width and depth, runtime min/max select, defined NaN and signed-zero semantics, and real backpressure.
- Sits in the arith library as a drop-in dataflow operator.

Parameters:
- DATA_WIDTH, 32, float format width; legal values are 16, 32 and 64, and any other value is an elaboration error.
- LATENCY, 2, number of pipeline register stages; legal range 1..8.
- CANONICAL_NAN, 1, selects the NaN result: 1 = canonical quiet NaN, 0 = the first NaN operand with its quiet bit forced to 1 (lhs takes priority).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous and active-low (0 = reset)
- lhs  input  DATA_WIDTH  left operand
- lhs_op_max  input  1  per-token operation: 0 = minimum, 1 = maximum; sampled with lhs
- lhs_valid  input  1  lhs channel valid
- lhs_ready  output  1  lhs channel ready
- rhs  input  DATA_WIDTH  right operand
- rhs_valid  input  1  rhs channel valid
- rhs_ready  output  1  rhs channel ready
- result  output  DATA_WIDTH  selected value
- result_valid  output  1  result valid
- result_ready  input  1  downstream ready

Behaviour:
- Reset (rst=0, asynchronous): all stage valid bits clear immediately; result_valid=0; data registers clear to 0; result=0.
- Reset mid-operation: every in-flight token is discarded; no token is emitted after rst deasserts until new operands fire.
- Stages s[0..LATENCY-1] each hold a valid bit and data; s[LATENCY-1] drives result and result_valid.
- Advance chain:
  - adv[L-1] = !v[L-1] | result_ready
  - adv[i] = !v[i] | adv[i+1]
  - Bubbles collapse; the ready path is combinational through the stages.
- Join:
  - fire = lhs_valid & rhs_valid & adv[0]
  - lhs_ready = adv[0] & rhs_valid
  - rhs_ready = adv[0] & lhs_valid
  - A lone valid never consumes its operand.
- Latency: a token firing in cycle t presents result_valid in cycle t+LATENCY when nothing stalls. Throughput is one token per cycle.
- Stall: while result_valid=1 and result_ready=0, result must hold stable; upstream stages keep filling until all are full, then lhs_ready and rhs_ready drop.
- Compute, combinational, before s[0]:
  - If either operand is NaN (exponent all ones, mantissa nonzero), the result is a NaN per CANONICAL_NAN. Canonical NaN is sign 0, exponent all ones, mantissa MSB 1, rest 0.
  - If the signs differ, the negative operand is smaller. This covers -0 < +0.
  - If both are positive, the larger magnitude is larger; if both are negative, the larger magnitude is smaller.
  - If the operands are bit-equal, return lhs.
  - Infinities follow the ordinary ordering; denormals are compared exactly, with no flush.
- Simultaneous events: s[L-1] draining and a new fire in the same cycle both occur; occupancy stays at LATENCY.

Decomposition:
- Package arith_float_pkg:
  - exp_width(DATA_WIDTH) function returning 5, 8 or 11.
  - man_width function, equal to DATA_WIDTH-1-exp_width.
  - canonical_qnan(DATA_WIDTH) function.
  - OP_MIN=0 and OP_MAX=1 constants.
- Sub-module fp_minmax_core: purely combinational, inputs a, b, op_max; outputs y and is_nan. It is reusable by a future clamp operator.
- Pipeline registers stay in minmaxf_pipe.

Test Plan:
- 32-bit, LATENCY=2, result_ready=1. Fire min(0x3F800000, 0x40000000) then max of the same operands → results 0x3F800000 then 0x40000000, valid 2 cycles after each fire, in back-to-back cycles.
- Signed zero: min(0x80000000, 0x00000000) → 0x80000000; max of the same → 0x00000000.
- NaN:
  - CANONICAL_NAN=1: min(0x7F800001, 0x3F800000) → 0x7FC00000.
  - CANONICAL_NAN=0: same min → 0x7FC00001.
  - CANONICAL_NAN=0: max(0xFF800000, 0xFF900000) → 0xFFD00000.
- Backpressure: result_ready=0, stream 4 tokens → exactly 2 accepted, then lhs_ready=rhs_ready=0 and result held stable. Release → all 4 emitted in order, none lost or duplicated.
- Join skew: lhs_valid=1 for 3 cycles before rhs_valid → lhs_ready=0 during those cycles; exactly one token fires when both are valid.
- Reset mid-flight: assert rst=0 asynchronously with 2 tokens in flight → result_valid=0 within the same cycle. After release, no output appears until new operands fire.
